// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: frame handshake bus between the scan capture block and its consumer (SEG7_DP_CAPTURE_EN adds frame_dp)
interface seg7_scan_capture_if #(parameter int NUM_DIGITS = 4);
  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    overrun;
`ifdef SEG7_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0]   frame_dp;
  modport master (output frame_valid, frame_digits, digit_err, overrun, frame_dp, input frame_ready);
  modport slave  (input frame_valid, frame_digits, digit_err, overrun, frame_dp, output frame_ready);
`else
  modport master (output frame_valid, frame_digits, digit_err, overrun, input frame_ready);
  modport slave  (input frame_valid, frame_digits, digit_err, overrun, output frame_ready);
`endif
endinterface

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a scanned active-low 7-segment bus back into digit frames (SEG7_DP_CAPTURE_EN captures the decimal point)
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
`ifdef SEG7_DP_CAPTURE_EN
  input  logic                  seg_dp_in,
`endif
  input  logic [NUM_DIGITS-1:0] dig_sel_n,
  seg7_scan_capture_if.master   bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_DP_CAPTURE_EN
  localparam int PW = 8;
  logic [PW-1:0] raw;
  assign raw = {seg_dp_in, seg_in};
  logic [NUM_DIGITS-1:0] stg_dp;
`else
  localparam int PW = 7;
  logic [PW-1:0] raw;
  assign raw = seg_in;
`endif
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t                  state, state_n;
  logic [PW-1:0]           pat_m, pat_s, pat;
  logic [NUM_DIGITS-1:0]   sel_m, sel_s, mask, stg_err;
  logic [4*NUM_DIGITS-1:0] stg_code;
  logic [IW-1:0]           idx, cur_idx;
  logic [3:0]              cnt, cnt_n;
  logic                    one, latch, cap, full;
  logic [4:0]              dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0111111: decode = 5'h0E;
      default:    decode = 5'h1F;
    endcase
  endfunction

  assign full = &mask;
  assign dec  = decode(pat[6:0]);

  // two-flop synchronizer for the asynchronous display lines
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat_m <= '0;
      pat_s <= '0;
      sel_m <= '0;
      sel_s <= '0;
    end else begin
      pat_m <= raw;
      pat_s <= pat_m;
      sel_m <= dig_sel_n;
      sel_s <= sel_m;
    end

  // single-strobe detection and index of the active strobe
  always_comb begin
    one     = $onehot(~sel_s);
    cur_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!sel_s[i]) cur_idx = IW'(i);
  end

  // next-state logic: debounce a strobe/pattern pair, capture once, then wait for the strobe to move
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE:
        if (one) begin
          latch   = 1'b1;
          cnt_n   = 4'd1;
          state_n = SETTLE;
        end
      SETTLE:
        if (one && cur_idx == idx && pat_s == pat) begin
          cnt_n   = cnt + 4'd1;
          state_n = cnt_n == 4'(STABLE_CYCLES) ? CAPTURE : SETTLE;
        end else begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end
      CAPTURE: begin
        cap     = 1'b1;
        cnt_n   = 4'd0;
        state_n = HOLD;
      end
      default: state_n = sel_s[idx] ? IDLE : HOLD;
    endcase
  end

  // state register with the latched index and pattern under observation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      pat   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        idx <= cur_idx;
        pat <= pat_s;
      end
    end

  // staging slots and capture mask; a full mask is consumed on the following cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask     <= '0;
      stg_code <= '0;
      stg_err  <= '0;
`ifdef SEG7_DP_CAPTURE_EN
      stg_dp   <= '0;
`endif
    end else begin
      mask <= full ? '0 : cap ? mask | (NUM_DIGITS'(1) << idx) : mask;
      if (cap) begin
        stg_code[{idx, 2'b00} +: 4] <= dec[3:0];
        stg_err[idx]                <= dec[4];
`ifdef SEG7_DP_CAPTURE_EN
        stg_dp[idx]                 <= pat[7];
`endif
      end
    end

  // output frame register: load when free or being accepted, else drop the new frame and flag overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.frame_valid  <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.frame_digits <= '0;
      bus.digit_err    <= '0;
`ifdef SEG7_DP_CAPTURE_EN
      bus.frame_dp     <= '0;
`endif
    end else begin
      bus.frame_valid <= full | (bus.frame_valid & ~bus.frame_ready);
      bus.overrun     <= full & bus.frame_valid & ~bus.frame_ready;
      if (full && (!bus.frame_valid || bus.frame_ready)) begin
        bus.frame_digits <= stg_code;
        bus.digit_err    <= stg_err;
`ifdef SEG7_DP_CAPTURE_EN
        bus.frame_dp     <= stg_dp;
`endif
      end
    end
endmodule
